// File: rtl/mem_access_pkg.sv
// Shared types for the MEM stage: access-size codes, writeback selects and FSM states.
package mem_access_pkg;

    typedef enum logic [2:0] {
        DM_WORD   = 3'b000,
        DM_HALF_S = 3'b001,
        DM_HALF_U = 3'b010,
        DM_BYTE_S = 3'b011,
        DM_BYTE_U = 3'b100
    } dmtype_e;

    typedef enum logic [1:0] {
        WD_ALU = 2'b00,
        WD_MEM = 2'b01,
        WD_PC  = 2'b10
    } wdsel_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } size_e;

    // Unlisted codes fall back to a full-word access.
    function automatic size_e dm_size(input logic [2:0] dmtype);
        case (dmtype)
            DM_HALF_S, DM_HALF_U: return SZ_HALF;
            DM_BYTE_S, DM_BYTE_U: return SZ_BYTE;
            default:              return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_load_ext.sv
// Load-data lane extraction: shift the addressed byte/half down to bit 0, then extend.
module load_ext
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  dmtype_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata_i >> {addr_lo_i, 3'b000};
        case (dmtype_i)
            DM_HALF_S: data_o = {{16{shifted[15]}}, shifted[15:0]};
            DM_HALF_U: data_o = {16'h0000, shifted[15:0]};
            DM_BYTE_S: data_o = {{24{shifted[7]}}, shifted[7:0]};
            DM_BYTE_U: data_o = {24'h000000, shifted[7:0]};
            default:   data_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: issues data-memory requests, waits for completion with a bus timeout,
// and registers the result into the WB stage.
//   state | meaning
//   IDLE  | no access outstanding; aligned accesses request combinationally
//   WAIT  | request held on the bus until dm_ready or timeout
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        MEM_valid,
    input  logic [31:0] MEM_aluout,
    input  logic [31:0] MEM_wdata,
    input  logic [31:0] MEM_PC,
    input  logic [4:0]  MEM_rd,
    input  logic        MEM_RegWrite,
    input  logic [1:0]  MEM_WDSel,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic [2:0]  MEM_DMType,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ready,
    output logic        WB_valid,
    output logic [31:0] WB_aluout,
    output logic [31:0] WB_Data_in,
    output logic [31:0] WB_PC,
    output logic [1:0]  WB_WDSel,
    output logic [4:0]  WB_rd,
    output logic        WB_RegWrite,
    output logic        mem_stall,
    output logic        misalign,
    output logic        bus_err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     addr_q, wdata_q;
    logic [3:0]      be_q;
    logic            we_q;

    logic            wb_valid_q, wb_regwrite_q, misalign_q, bus_err_q;
    logic [31:0]     wb_aluout_q, wb_data_q, wb_pc_q;
    logic [1:0]      wb_wdsel_q;
    logic [4:0]      wb_rd_q;

    size_e           size;
    logic            access, mis, aligned_acc;
    logic [3:0]      be_c;
    logic [31:0]     wdata_c, ld_data;
    logic            req_c, stall_c, done_mem, timeout, wb_load, capture;

    always_comb begin
        access      = MEM_valid & (MEM_MemRead | MEM_MemWrite);
        size        = dm_size(MEM_DMType);
        mis         = access & (((size == SZ_WORD) && (MEM_aluout[1:0] != 2'b00)) ||
                                ((size == SZ_HALF) && MEM_aluout[0]));
        aligned_acc = access & ~mis;
        case (size)
            SZ_BYTE: begin
                be_c    = 4'b0001 << MEM_aluout[1:0];
                wdata_c = {4{MEM_wdata[7:0]}};
            end
            SZ_HALF: begin
                be_c    = 4'b0011 << MEM_aluout[1:0];
                wdata_c = {2{MEM_wdata[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = MEM_wdata;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_c    = 1'b0;
        stall_c  = 1'b0;
        done_mem = 1'b0;
        timeout  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (aligned_acc) begin
                    req_c = 1'b1;
                    if (dm_ready) begin
                        done_mem = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            ST_WAIT: begin
                req_c = 1'b1;
                if (dm_ready) begin
                    done_mem = 1'b1;
                    state_d  = ST_IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // Give up: drop the request this cycle and retire the instruction as a bubble-write.
                    req_c   = 1'b0;
                    timeout = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign capture = (state_q == ST_IDLE) && (state_d == ST_WAIT);
    assign wb_load = ((state_q == ST_IDLE) && MEM_valid && !aligned_acc) || done_mem || timeout;

    // Combinational bus outputs are forced low while reset is asserted.
    always_comb begin
        dm_req    = rstn & req_c;
        mem_stall = rstn & stall_c;
        if (!rstn) begin
            dm_we    = 1'b0;
            dm_addr  = '0;
            dm_wdata = '0;
            dm_be    = '0;
        end else if (state_q == ST_WAIT) begin
            dm_we    = req_c & we_q;
            dm_addr  = addr_q;
            dm_wdata = wdata_q;
            dm_be    = be_q;
        end else begin
            dm_we    = req_c & MEM_MemWrite;
            dm_addr  = {MEM_aluout[31:2], 2'b00};
            dm_wdata = wdata_c;
            dm_be    = be_c;
        end
    end

    load_ext u_load_ext (
        .rdata_i   (dm_rdata),
        .addr_lo_i (MEM_aluout[1:0]),
        .dmtype_i  (MEM_DMType),
        .data_o    (ld_data)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                addr_q  <= {MEM_aluout[31:2], 2'b00};
                wdata_q <= wdata_c;
                be_q    <= be_c;
                we_q    <= MEM_MemWrite;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wb_valid_q    <= 1'b0;
            wb_regwrite_q <= 1'b0;
            misalign_q    <= 1'b0;
            bus_err_q     <= 1'b0;
            wb_aluout_q   <= '0;
            wb_data_q     <= '0;
            wb_pc_q       <= '0;
            wb_wdsel_q    <= '0;
            wb_rd_q       <= '0;
        end else begin
            wb_valid_q    <= wb_load;
            wb_regwrite_q <= wb_load & MEM_RegWrite & ~mis & ~timeout;
            misalign_q    <= (state_q == ST_IDLE) & mis;
            bus_err_q     <= timeout;
            if (wb_load) begin
                wb_aluout_q <= MEM_aluout;
                wb_data_q   <= ld_data;
                wb_pc_q     <= MEM_PC;
                wb_wdsel_q  <= MEM_WDSel;
                wb_rd_q     <= MEM_rd;
            end
        end
    end

    assign WB_valid    = wb_valid_q;
    assign WB_RegWrite = wb_regwrite_q;
    assign WB_aluout   = wb_aluout_q;
    assign WB_Data_in  = wb_data_q;
    assign WB_PC       = wb_pc_q;
    assign WB_WDSel    = wb_wdsel_q;
    assign WB_rd       = wb_rd_q;
    assign misalign    = misalign_q;
    assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: each driven instruction pushes its expected WB result,
// a negedge monitor pops and compares whenever WB_valid is seen.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rstn;
    logic        MEM_valid, MEM_RegWrite, MEM_MemRead, MEM_MemWrite;
    logic [31:0] MEM_aluout, MEM_wdata, MEM_PC;
    logic [4:0]  MEM_rd;
    logic [1:0]  MEM_WDSel;
    logic [2:0]  MEM_DMType;
    logic        dm_req, dm_we, dm_ready;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        WB_valid, WB_RegWrite, mem_stall, misalign, bus_err;
    logic [31:0] WB_aluout, WB_Data_in, WB_PC;
    logic [1:0]  WB_WDSel;
    logic [4:0]  WB_rd;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        regwrite;
        logic [31:0] data;
        logic        chk_data;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [1:0]  wdsel;
        logic        mis;
        logic        berr;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] pc_ctr = 32'h0000_1000;
    logic [4:0]  rd_ctr = 5'd1;

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT(16)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .MEM_valid    (MEM_valid),
        .MEM_aluout   (MEM_aluout),
        .MEM_wdata    (MEM_wdata),
        .MEM_PC       (MEM_PC),
        .MEM_rd       (MEM_rd),
        .MEM_RegWrite (MEM_RegWrite),
        .MEM_WDSel    (MEM_WDSel),
        .MEM_MemRead  (MEM_MemRead),
        .MEM_MemWrite (MEM_MemWrite),
        .MEM_DMType   (MEM_DMType),
        .dm_req       (dm_req),
        .dm_we        (dm_we),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_be        (dm_be),
        .dm_rdata     (dm_rdata),
        .dm_ready     (dm_ready),
        .WB_valid     (WB_valid),
        .WB_aluout    (WB_aluout),
        .WB_Data_in   (WB_Data_in),
        .WB_PC        (WB_PC),
        .WB_WDSel     (WB_WDSel),
        .WB_rd        (WB_rd),
        .WB_RegWrite  (WB_RegWrite),
        .mem_stall    (mem_stall),
        .misalign     (misalign),
        .bus_err      (bus_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rstn) begin
            if (WB_valid) begin
                if (sbq.size() == 0) begin
                    check("wb_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("wb_regwrite", {31'd0, WB_RegWrite}, {31'd0, e.regwrite});
                    check("wb_aluout", WB_aluout, e.alu);
                    check("wb_pc", WB_PC, e.pc);
                    check("wb_rd", {27'd0, WB_rd}, {27'd0, e.rd});
                    check("wb_wdsel", {30'd0, WB_WDSel}, {30'd0, e.wdsel});
                    check("misalign", {31'd0, misalign}, {31'd0, e.mis});
                    check("bus_err", {31'd0, bus_err}, {31'd0, e.berr});
                    if (e.chk_data) check("wb_data", WB_Data_in, e.data);
                end
            end else begin
                check("pulse_in_bubble", {30'd0, misalign, bus_err}, 32'd0);
            end
        end
    end

    task automatic run_op(input logic rd_en, input logic we_en, input logic [2:0] dmt,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic rw_in,
                          input logic [1:0] wdsel, input int waits, input logic [31:0] rdata,
                          input logic exp_req, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input int exp_stalls, input logic [31:0] exp_data, input logic chk_data,
                          input logic exp_mis, input logic exp_berr);
        exp_t e;
        int   stalls = 0;
        logic done   = 1'b0;
        e.regwrite = rw_in & ~exp_mis & ~exp_berr;
        e.data     = exp_data;
        e.chk_data = chk_data;
        e.alu      = addr;
        e.pc       = pc_ctr;
        e.rd       = rd_ctr;
        e.wdsel    = wdsel;
        e.mis      = exp_mis;
        e.berr     = exp_berr;
        sbq.push_back(e);
        MEM_valid    = 1'b1;
        MEM_MemRead  = rd_en;
        MEM_MemWrite = we_en;
        MEM_DMType   = dmt;
        MEM_aluout   = addr;
        MEM_wdata    = wdata;
        MEM_RegWrite = rw_in;
        MEM_WDSel    = wdsel;
        MEM_PC       = pc_ctr;
        MEM_rd       = rd_ctr;
        for (int c = 0; c < 200 && !done; c++) begin
            dm_ready = (c >= waits);
            dm_rdata = rdata;
            @(negedge clk);
            if (c == 0) begin
                check("dm_req", {31'd0, dm_req}, {31'd0, exp_req});
                if (exp_req) begin
                    check("dm_we", {31'd0, dm_we}, {31'd0, we_en});
                    check("dm_addr", dm_addr, addr & ~32'h3);
                    check("dm_be", {28'd0, dm_be}, {28'd0, exp_be});
                    if (we_en) check("dm_wdata", dm_wdata, exp_wd);
                end
            end else if (dm_req) begin
                check("hold_addr", dm_addr, addr & ~32'h3);
                check("hold_be", {28'd0, dm_be}, {28'd0, exp_be});
                check("hold_we", {31'd0, dm_we}, {31'd0, we_en});
            end
            if (mem_stall) stalls++;
            else done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) check("op_bound", 32'd0, 32'd1);
        check("stall_cycles", stalls, exp_stalls);
        MEM_valid    = 1'b0;
        MEM_MemRead  = 1'b0;
        MEM_MemWrite = 1'b0;
        dm_ready     = 1'b0;
        pc_ctr       = pc_ctr + 32'd4;
        rd_ctr       = rd_ctr + 5'd1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0;
        MEM_valid = 1'b1; MEM_MemRead = 1'b1; MEM_MemWrite = 1'b0;
        MEM_aluout = 32'h100; MEM_wdata = '0; MEM_PC = '0; MEM_rd = '0;
        MEM_RegWrite = 1'b1; MEM_WDSel = 2'b01; MEM_DMType = 3'b000;
        dm_ready = 1'b0; dm_rdata = '0;
        #12;
        check("rst_dm_req", {31'd0, dm_req}, 32'd0);
        check("rst_stall", {31'd0, mem_stall}, 32'd0);
        check("rst_wb_valid", {31'd0, WB_valid}, 32'd0);
        check("rst_wb_wdsel", {30'd0, WB_WDSel}, 32'd0);
        check("rst_wb_data", WB_Data_in, 32'd0);
        MEM_valid = 1'b0; MEM_MemRead = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        //     rd we dmt     addr          wdata         rw wds   wt    rdata         req be       wd            st  data          cd mis berr
        run_op(1, 0, 3'b000, 32'h0000_0100, 32'h0,        1, 2'b01, 0,   32'hDEAD_BEEF, 1, 4'b1111, 32'h0,        0,  32'hDEAD_BEEF, 1, 0, 0);
        run_op(1, 0, 3'b011, 32'h0000_0103, 32'h0,        1, 2'b01, 2,   32'h80FF_00FF, 1, 4'b1000, 32'h0,        2,  32'hFFFF_FF80, 1, 0, 0);
        run_op(0, 1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 0, 2'b00, 1,   32'h0,         1, 4'b1100, 32'hABCD_ABCD, 1,  32'h0,         0, 0, 0);
        run_op(1, 0, 3'b000, 32'h0000_0101, 32'h0,        1, 2'b01, 0,   32'h0,         0, 4'b0000, 32'h0,        0,  32'h0,         0, 1, 0);
        run_op(1, 0, 3'b000, 32'h0000_0400, 32'h0,        1, 2'b01, 1000, 32'h0,        1, 4'b1111, 32'h0,        16, 32'h0,         0, 0, 1);
        run_op(1, 0, 3'b010, 32'h0000_0102, 32'h0,        1, 2'b01, 0,   32'h8765_4321, 1, 4'b1100, 32'h0,        0,  32'h0000_8765, 1, 0, 0);
        run_op(1, 0, 3'b001, 32'h0000_0100, 32'h0,        1, 2'b01, 3,   32'h1234_8001, 1, 4'b0011, 32'h0,        3,  32'hFFFF_8001, 1, 0, 0);
        run_op(1, 0, 3'b100, 32'h0000_0101, 32'h0,        1, 2'b01, 1,   32'h1122_C344, 1, 4'b0010, 32'h0,        1,  32'h0000_00C3, 1, 0, 0);
        run_op(0, 0, 3'b000, 32'h1234_5679, 32'h0,        1, 2'b10, 0,   32'h0,         0, 4'b0000, 32'h0,        0,  32'h0,         0, 0, 0);
        run_op(0, 1, 3'b011, 32'h0000_0101, 32'h0000_00A5, 0, 2'b00, 0,   32'h0,         1, 4'b0010, 32'hA5A5_A5A5, 0,  32'h0,         0, 0, 0);
        run_op(0, 1, 3'b000, 32'h0000_0200, 32'hCAFE_F00D, 0, 2'b00, 2,   32'h0,         1, 4'b1111, 32'hCAFE_F00D, 2,  32'h0,         0, 0, 0);
        run_op(1, 0, 3'b001, 32'h0000_0101, 32'h0,        1, 2'b01, 0,   32'h0,         0, 4'b0000, 32'h0,        0,  32'h0,         0, 1, 0);
        run_op(1, 1, 3'b000, 32'h0000_0204, 32'h0102_0304, 0, 2'b00, 1,   32'h0,         1, 4'b1111, 32'h0102_0304, 1,  32'h0,         0, 0, 0);
        run_op(1, 0, 3'b011, 32'h0000_0102, 32'h0,        1, 2'b01, 0,   32'h007F_0000, 1, 4'b0100, 32'h0,        0,  32'h0000_007F, 1, 0, 0);
        run_op(1, 0, 3'b111, 32'h0000_0104, 32'h0,        1, 2'b01, 0,   32'h55AA_55AA, 1, 4'b1111, 32'h0,        0,  32'h55AA_55AA, 1, 0, 0);

        MEM_valid = 1'b0; MEM_MemRead = 1'b1; MEM_aluout = 32'h0000_0300;
        @(negedge clk);
        check("no_req_when_invalid", {31'd0, dm_req}, 32'd0);
        @(posedge clk);
        #1;

        // Abandon an access mid-WAIT with an asynchronous reset.
        MEM_valid = 1'b1; MEM_MemRead = 1'b1; MEM_MemWrite = 1'b0;
        MEM_DMType = 3'b000; MEM_aluout = 32'h0000_0300; dm_ready = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("wait_req_before_rst", {31'd0, dm_req}, 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("rst_wait_dm_req", {31'd0, dm_req}, 32'd0);
        check("rst_wait_stall", {31'd0, mem_stall}, 32'd0);
        check("rst_wait_wb_valid", {31'd0, WB_valid}, 32'd0);
        MEM_valid = 1'b0; MEM_MemRead = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        run_op(1, 0, 3'b000, 32'h0000_0308, 32'h0,        1, 2'b01, 0,   32'h0BAD_CAFE, 1, 4'b1111, 32'h0,        0,  32'h0BAD_CAFE, 1, 0, 0);

        repeat (3) @(posedge clk);
        check("sb_empty", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
